// File: rtl/id_ex_issue_ctrl.sv
// ID/EX issue controller: holds the packed decode word for execute, inserts
// load-use bubbles, discards wrong-path words after taken branches, counts stalls.
module id_ex_issue_ctrl #(
    parameter int LOAD_LAT   = 2,
    parameter int FLUSH_DROP = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [39:0]      id_ctrl,
    output logic             id_ready,
    output logic             ex_valid,
    output logic [39:0]      ex_ctrl,
    input  logic             ex_ready,
    input  logic             branch_taken,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             flushing
);

    typedef struct packed {
        logic [3:0] af;
        logic       i;
        logic       alu_mux_sel;
        logic [2:0] shift_type;
        logic [4:0] cad;
        logic       gp_we;
        logic [1:0] gp_mux_sel;
        logic [3:0] bf;
        logic [1:0] pc_mux_select;
        logic       mem_wren;
        logic       mem_rren;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } dec_t;

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [2:0] LAT3     = 3'(LOAD_LAT);
    localparam logic [2:0] DROP3    = 3'(FLUSH_DROP);
    localparam bit         HAS_DROP = (FLUSH_DROP > 0);

    function automatic logic is_load(input dec_t w);
        return w.mem_rren && w.gp_we && (w.cad != 5'd0);
    endfunction

    // rt is a real source for R-type, stores and branches; I-type ALU ops ignore it
    function automatic logic reads_reg(input dec_t w, input logic [4:0] r);
        logic rt_used;
        rt_used = (w.rt != 5'd0) && (!w.i || w.mem_wren || (w.bf != 4'd0));
        return (r != 5'd0) && (((w.rs != 5'd0) && (w.rs == r)) || (rt_used && (w.rt == r)));
    endfunction

    state_t     state;
    logic [2:0] drop_cnt;
    logic [2:0] trk_cnt;
    logic [4:0] trk_cad;

    logic adv, br_take, hazard, ex_is_load;

    always_comb begin
        adv        = !ex_valid || ex_ready;
        br_take    = branch_taken && ex_valid && ex_ready;
        ex_is_load = is_load(dec_t'(ex_ctrl));
        hazard     = 1'b0;
        if (id_valid && (state == RUN)) begin
            if (ex_valid && ex_is_load && reads_reg(dec_t'(id_ctrl), ex_ctrl[30:26]))
                hazard = 1'b1;
            // trk_cnt==1 means the result is forwardable this cycle
            if ((trk_cnt > 3'd1) && reads_reg(dec_t'(id_ctrl), trk_cad))
                hazard = 1'b1;
        end
    end

    assign flushing = (state == FLUSH);
    assign id_ready = br_take || flushing || (adv && !hazard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            drop_cnt <= 3'd0;
            ex_valid <= 1'b0;
            ex_ctrl  <= 40'd0;
        end else if (br_take) begin
            ex_valid <= 1'b0;
            if (HAS_DROP) begin
                state    <= FLUSH;
                drop_cnt <= DROP3;
            end
        end else if (state == FLUSH) begin
            ex_valid <= 1'b0;
            drop_cnt <= drop_cnt - 3'd1;
            if (drop_cnt == 3'd1)
                state <= RUN;
        end else if (adv) begin
            if (id_valid && !hazard) begin
                ex_valid <= 1'b1;
                ex_ctrl  <= id_ctrl;
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end

    // Remembers the most recent load to leave EX until its result is forwardable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_cnt <= 3'd0;
            trk_cad <= 5'd0;
        end else if (ex_valid && ex_ready && ex_is_load) begin
            trk_cad <= ex_ctrl[30:26];
            trk_cnt <= LAT3;
        end else if (trk_cnt != 3'd0) begin
            trk_cnt <= trk_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (id_valid && !id_ready && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_id_ex_issue_ctrl.sv
// Scoreboard bench for id_ex_issue_ctrl: directed scenarios plus random traffic
// checked against a timestamp-based model of load-use, flush and stall rules.
module tb_id_ex_issue_ctrl;

    localparam int LAT  = 2;
    localparam int DROP = 1;
    localparam int CW   = 4;
    localparam int SMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [39:0]   id_ctrl = '0;
    logic          id_ready;
    logic          ex_valid;
    logic [39:0]   ex_ctrl;
    logic          ex_ready = 1'b0;
    logic          branch_taken = 1'b0;
    logic [CW-1:0] stall_cycles;
    logic          flushing;

    always #5 clk = ~clk;

    id_ex_issue_ctrl #(.LOAD_LAT(LAT), .FLUSH_DROP(DROP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_ready(id_ready), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_ready(ex_ready), .branch_taken(branch_taken),
        .stall_cycles(stall_cycles), .flushing(flushing)
    );

    typedef struct {
        logic        rdy;
        logic        exv;
        logic [39:0] exw;
        logic        fl;
        int          st;
    } exp_t;

    exp_t        exp_q[$];
    logic [39:0] word_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    // reference model state: abstract pipeline register, flush countdown,
    // and the exit cycle of the most recent load
    bit          m_exv;
    logic [39:0] m_exw;
    int          m_flush, m_stall, cyc;
    bit          ld_has;
    logic [4:0]  ld_cad;
    int          ld_exit;

    logic        s_rdy, s_exv, s_fl;
    logic [39:0] s_exw;
    int          s_st;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_ld(input logic [39:0] w);
        return w[15] && w[25] && (w[30:26] != 5'd0);
    endfunction

    function automatic bit reads(input logic [39:0] w, input logic [4:0] r);
        bit rt_src;
        rt_src = !w[35] || w[16] || (w[22:19] != 4'd0);
        return (r != 5'd0) && ((w[14:10] == r) || (rt_src && (w[9:5] == r)));
    endfunction

    function automatic logic [39:0] mk(input bit ld, input logic [4:0] cad, input logic [4:0] rs,
                                       input logic [4:0] rt, input bit i, input bit wren,
                                       input logic [3:0] bf, input logic [4:0] rd);
        logic [39:0] w;
        w = '0;
        w[35]    = i;
        w[30:26] = cad;
        w[25]    = !wren && (bf == 4'd0);
        w[22:19] = bf;
        w[16]    = wren;
        w[15]    = ld;
        w[14:10] = rs;
        w[9:5]   = rt;
        w[4:0]   = rd;
        return w;
    endfunction

    task automatic model_clear();
        m_exv = 0; m_exw = '0; m_flush = 0; m_stall = 0;
        ld_has = 0; ld_cad = '0; ld_exit = 0;
        word_q.delete();
    endtask

    task automatic snap();
        s_rdy = id_ready; s_exv = ex_valid; s_exw = ex_ctrl;
        s_fl = flushing; s_st = int'(stall_cycles);
    endtask

    task automatic step(input bit v, input logic [39:0] w, input bit rdy, input bit br, output bit acc);
        bit adv, take, haz, r_exp;
        exp_t e;
        @(posedge clk); #1;
        id_valid = v; id_ctrl = w; ex_ready = rdy; branch_taken = br;
        adv  = !m_exv || rdy;
        take = br && m_exv && rdy;
        haz  = (m_flush == 0) && v &&
               ((m_exv && is_ld(m_exw) && reads(w, m_exw[30:26])) ||
                (ld_has && (cyc - ld_exit < LAT) && reads(w, ld_cad)));
        r_exp = take || (m_flush > 0) || (adv && !haz);
        e.rdy = r_exp; e.exv = m_exv; e.exw = m_exw; e.fl = (m_flush > 0); e.st = m_stall;
        exp_q.push_back(e);
        if (v && !r_exp && m_stall < SMAX) m_stall++;
        if (m_exv && rdy && is_ld(m_exw)) begin
            ld_has = 1; ld_cad = m_exw[30:26]; ld_exit = cyc;
        end
        if (take) begin
            m_exv = 0; m_flush = DROP;
        end else if (m_flush > 0) begin
            m_exv = 0; m_flush--;
        end else if (adv) begin
            if (v && !haz) begin
                m_exv = 1; m_exw = w; word_q.push_back(w);
            end else begin
                m_exv = 0;
            end
        end
        cyc++;
        acc = r_exp;
        #1 snap();
    endtask

    // asynchronous reset asserted mid-cycle, held across one edge
    task automatic do_reset();
        exp_t e;
        @(posedge clk); #2;
        rst_n = 0; id_valid = 0; ex_ready = 0; branch_taken = 0;
        model_clear();
        e.rdy = 1; e.exv = 0; e.exw = '0; e.fl = 0; e.st = 0;
        exp_q.push_back(e);
        #1;
        chk("rst_ex_valid", 64'(ex_valid), 0);
        chk("rst_ex_ctrl", 64'(ex_ctrl), 0);
        chk("rst_stall", 64'(stall_cycles), 0);
        chk("rst_flushing", 64'(flushing), 0);
        @(posedge clk); #1;
        rst_n = 1;
        exp_q.push_back(e);
        cyc++;
    endtask

    // monitor: pops one expectation per cycle and checks the consumed word stream
    initial begin
        exp_t e;
        logic [39:0] wexp;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("id_ready", 64'(id_ready), 64'(e.rdy));
                chk("ex_valid", 64'(ex_valid), 64'(e.exv));
                if (e.exv) chk("ex_ctrl", 64'(ex_ctrl), 64'(e.exw));
                chk("flushing", 64'(flushing), 64'(e.fl));
                chk("stall_cycles", 64'(stall_cycles), 64'(e.st));
                if (rst_n && ex_valid && ex_ready) begin
                    if (word_q.size() == 0) begin
                        chk("ex_word_unexpected", 64'(ex_ctrl), 64'hdead);
                    end else begin
                        wexp = word_q.pop_front();
                        chk("ex_word", 64'(ex_ctrl), 64'(wexp));
                    end
                end
            end
        end
    end

    initial begin
        bit acc;
        logic [39:0] lw5, add5, lw7, addi7, wa, wb, beq, w1, w2, w3, cur;
        bit cur_v;
        cyc = 0;
        model_clear();
        lw5   = mk(1, 5'd5, 5'd1, 5'd0, 1, 0, 4'd0, 5'd0);
        add5  = mk(0, 5'd6, 5'd5, 5'd2, 0, 0, 4'd0, 5'd6);
        lw7   = mk(1, 5'd7, 5'd1, 5'd0, 1, 0, 4'd0, 5'd0);
        addi7 = mk(0, 5'd8, 5'd0, 5'd7, 1, 0, 4'd0, 5'd0);
        wa    = mk(0, 5'd9, 5'd1, 5'd2, 0, 0, 4'd0, 5'd9);
        wb    = mk(0, 5'd10, 5'd3, 5'd4, 0, 0, 4'd0, 5'd10);
        beq   = mk(0, 5'd0, 5'd1, 5'd2, 1, 0, 4'd1, 5'd0);
        w1    = mk(0, 5'd11, 5'd1, 5'd0, 1, 0, 4'd0, 5'd0);
        w2    = mk(0, 5'd12, 5'd2, 5'd0, 1, 0, 4'd0, 5'd0);
        w3    = mk(0, 5'd13, 5'd3, 5'd0, 1, 0, 4'd0, 5'd0);

        do_reset();

        // streaming ALU words
        for (int k = 0; k < 4; k++) begin
            step(1, mk(0, 5'(k + 1), 5'(k + 16), 5'(k + 20), 0, 0, 4'd0, 5'(k + 1)), 1, 0, acc);
            chk("strm_rdy", 64'(s_rdy), 1);
            if (k > 0) chk("strm_ex", 64'(s_exw), 64'(mk(0, 5'(k), 5'(k + 15), 5'(k + 19), 0, 0, 4'd0, 5'(k))));
        end
        step(0, '0, 1, 0, acc);
        chk("strm_stall", 64'(s_st), 0);

        // load-use, two bubbles
        do_reset();
        step(1, lw5, 1, 0, acc);   chk("lu_rdy0", 64'(s_rdy), 1);
        step(1, add5, 1, 0, acc);  chk("lu_rdy1", 64'(s_rdy), 0); chk("lu_lw_in_ex", 64'(s_exw), 64'(lw5));
        step(1, add5, 1, 0, acc);  chk("lu_rdy2", 64'(s_rdy), 0); chk("lu_bubble1", 64'(s_exv), 0);
        step(1, add5, 1, 0, acc);  chk("lu_rdy3", 64'(s_rdy), 1); chk("lu_bubble2", 64'(s_exv), 0);
        step(0, '0, 1, 0, acc);    chk("lu_add_ex", 64'(s_exw), 64'(add5)); chk("lu_stall", 64'(s_st), 2);

        // immediate op does not read rt
        do_reset();
        step(1, lw7, 1, 0, acc);
        step(1, addi7, 1, 0, acc); chk("imm_rdy", 64'(s_rdy), 1);
        step(0, '0, 1, 0, acc);    chk("imm_stall", 64'(s_st), 0);

        // downstream backpressure
        do_reset();
        step(1, wa, 1, 0, acc);
        for (int k = 0; k < 3; k++) begin
            step(1, wb, 0, 0, acc);
            chk("bp_rdy", 64'(s_rdy), 0);
            chk("bp_hold", 64'(s_exw), 64'(wa));
            chk("bp_valid", 64'(s_exv), 1);
        end
        step(1, wb, 1, 0, acc);    chk("bp_stall", 64'(s_st), 3);

        // taken branch with one drop cycle
        do_reset();
        step(1, beq, 1, 0, acc);
        step(1, w1, 1, 1, acc);    chk("br_rdy", 64'(s_rdy), 1); chk("br_fl0", 64'(s_fl), 0);
        step(1, w2, 1, 0, acc);    chk("fl_rdy", 64'(s_rdy), 1); chk("fl_on", 64'(s_fl), 1); chk("fl_exv", 64'(s_exv), 0);
        step(1, w3, 1, 0, acc);    chk("fl_off", 64'(s_fl), 0); chk("fl_exv2", 64'(s_exv), 0); chk("fl_rdy3", 64'(s_rdy), 1);
        step(0, '0, 1, 0, acc);    chk("fl_next", 64'(s_exw), 64'(w3)); chk("fl_stall", 64'(s_st), 0);

        // reset mid-stall clears tracker
        do_reset();
        step(1, lw5, 1, 0, acc);
        step(1, add5, 1, 0, acc);  chk("rs_stalled", 64'(s_rdy), 0);
        do_reset();
        step(1, add5, 1, 0, acc);  chk("rs_no_stall", 64'(s_rdy), 1);

        // reset mid-flush
        step(1, beq, 1, 0, acc);
        step(1, w1, 1, 1, acc);
        step(1, w2, 1, 0, acc);    chk("rf_in_flush", 64'(s_fl), 1);
        do_reset();
        step(1, w3, 1, 0, acc);    chk("rf_run", 64'(s_fl), 0); chk("rf_rdy", 64'(s_rdy), 1);

        // stall counter saturation
        do_reset();
        step(1, wa, 1, 0, acc);
        for (int k = 0; k < SMAX + 3; k++) step(1, wb, 0, 0, acc);
        chk("sat_stall", 64'(s_st), 64'(SMAX));

        // random traffic
        do_reset();
        cur_v = 0; cur = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                cur_v = 0;
            end
            if (!cur_v || acc) begin
                bit ld;
                ld = ($urandom_range(0, 2) == 0);
                cur_v = ($urandom_range(0, 3) != 0);
                cur = mk(ld, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         !ld && ($urandom_range(0, 5) == 0),
                         (!ld && $urandom_range(0, 3) == 0) ? 4'd1 : 4'd0,
                         5'($urandom_range(0, 31)));
                cur[39:36] = 4'($urandom_range(0, 15));
            end
            step(cur_v, cur, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), acc);
            if (!cur_v) acc = 1;
        end

        step(0, '0, 1, 0, acc);
        @(posedge clk); @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
